// File: rtl/fd_pipe_stage.sv
// ============================================================================
// fd_pipe_stage
// ----------------------------------------------------------------------------
// Fetch->decode pipeline register with a valid/ready handshake. It carries an
// instruction word and its PC from fetch to decode.
//
// With SKID=1 the stage holds two entries: a main entry that drives the
// outputs, and a skid entry behind it. in_ready then depends only on a flop,
// so the fetch side never sees a combinational path from out_ready, and the
// stage still moves one word per cycle.
// With SKID=0 the stage holds a single entry. in_ready is combinational from
// out_ready, so a word can be replaced in the same cycle that it is consumed.
//
// flush squashes every held entry, for example on a branch or jump redirect.
// While the stage is empty it drives NOP_INST and a zero address.
//
// Parameters
//   INST_W    instruction word width
//   ADDR_W    instruction address width
//   SKID      1: main + skid entries, registered in_ready; 0: single entry
//   NOP_INST  value driven on out_inst while the stage is empty
//
// Ports
//   clk        in   1       clock; all state updates on posedge
//   rst        in   1       synchronous reset, active-high, overrides flush
//   flush      in   1       squash all held entries this cycle
//   in_valid   in   1       fetch presents a word
//   in_ready   out  1       stage can accept a word this cycle
//   in_inst    in   INST_W  fetched instruction
//   in_addr    in   ADDR_W  PC of the fetched instruction
//   out_valid  out  1       decode-side word is valid
//   out_ready  in   1       decode consumes the word this cycle
//   out_inst   out  INST_W  held instruction (NOP_INST when empty)
//   out_addr   out  ADDR_W  held PC (zero when empty)
//   occupancy  out  2       number of held entries (0..2, 0..1 when SKID=0)
// ============================================================================
module fd_pipe_stage #(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        ADDR_W   = 32,
    parameter bit                 SKID     = 1'b1,
    parameter logic [INST_W-1:0]  NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        occupancy
);

    // ------------------------------------------------------------------------
    // State encoding. The state is the number of valid entries, so occupancy
    // can be read straight from it and no separate counter is needed.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,    // nothing held
        ST_ONE   = 2'd1,    // main entry valid
        ST_FULL  = 2'd2     // main and skid entries valid (SKID=1 only)
    } state_t;

    // Sources for the next value of the main entry.
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_FROM_IN   = 2'd1,
        MAIN_FROM_SKID = 2'd2,
        MAIN_CLEAR     = 2'd3
    } main_sel_t;

    state_t            state_q;
    state_t            state_d;
    main_sel_t         main_sel;
    logic              skid_load;

    logic [INST_W-1:0] main_inst_q;
    logic [ADDR_W-1:0] main_addr_q;
    logic [INST_W-1:0] skid_inst_q;
    logic [ADDR_W-1:0] skid_addr_q;

    logic              skid_valid;
    logic              accept;
    logic              emit;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign out_valid  = (state_q != ST_EMPTY);
    // skid_valid is a decode of the state flop, so in_ready stays registered.
    assign skid_valid = (state_q == ST_FULL);
    assign accept     = in_valid & in_ready;
    assign emit       = out_valid & out_ready;

    generate
        if (SKID) begin : g_ready_skid
            // The skid entry absorbs the word that arrives in the same cycle
            // that decode stalls, so in_ready only has to look at the skid flop.
            assign in_ready = ~skid_valid & ~flush & ~rst;
        end else begin : g_ready_single
            // With one entry, a word can be accepted only if the current word
            // is leaving in this cycle or the stage is already empty.
            assign in_ready = (~out_valid | out_ready) & ~flush & ~rst;
        end
    endgenerate

    assign out_inst = main_inst_q;
    assign out_addr = main_addr_q;

    always_comb begin
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath steering
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal is given a default first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;

        if (flush) begin
            // A word that decode takes in this cycle has already been consumed.
            // Every word still held, and any word presented now, is dropped.
            state_d  = ST_EMPTY;
            main_sel = MAIN_CLEAR;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        main_sel = MAIN_FROM_IN;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_sel = MAIN_FROM_IN;
                    end else if (accept && SKID) begin
                        // Decode stalled: park the new word behind main so
                        // that FIFO order is preserved.
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (emit) begin
                        state_d  = ST_EMPTY;
                        main_sel = MAIN_CLEAR;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the only way out is through emit.
                    if (emit) begin
                        state_d  = ST_ONE;
                        main_sel = MAIN_FROM_SKID;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_sel = MAIN_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and main entry. Reset is synchronous and takes priority over flush.
    // The main entry is reset because it drives out_inst/out_addr directly and
    // must show NOP_INST and a zero address while the stage is empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only, so every
        // flop samples values from before the clock edge.
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= NOP_INST;
            main_addr_q <= '0;
        end else begin
            state_q <= state_d;
            case (main_sel)
                MAIN_FROM_IN: begin
                    main_inst_q <= in_inst;
                    main_addr_q <= in_addr;
                end
                MAIN_FROM_SKID: begin
                    main_inst_q <= skid_inst_q;
                    main_addr_q <= skid_addr_q;
                end
                MAIN_CLEAR: begin
                    main_inst_q <= NOP_INST;
                    main_addr_q <= '0;
                end
                default: begin
                    main_inst_q <= main_inst_q;
                    main_addr_q <= main_addr_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Skid entry data.
    // ------------------------------------------------------------------------
    // NOTE: the skid payload has no reset. It is only read when the state is
    // ST_FULL, and the state itself is reset, so stale contents can never be
    // observed. Leaving it unreset saves reset routing to a wide register.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_inst_q <= in_inst;
            skid_addr_q <= in_addr;
        end
    end

endmodule
